hazard_stall: RTL and testbench
===============================

HAZARD_STALL -- requirements
Module: hazard_stall

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single pipeline clock, rising-edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port id_instru, input, 32 bits: IF/ID.instru.
REQ-004 SHALL have port ex_instru, input, 32 bits: ID/EX.instru.
REQ-005 SHALL have port ex_mem_instru, input, 32 bits: EX/MEM.instru.
REQ-006 SHALL have port c_ex_MemRead, input, 1 bit: ID/EX.MemRead.
REQ-007 SHALL have port c_ex_RegWrite, input, 1 bit: ID/EX.RegWrite.
REQ-008 SHALL have port c_ex_mem_MemRead, input, 1 bit: EX/MEM.MemRead.
REQ-009 SHALL have port c_id_branch_taken, input, 1 bit: beq/bne in ID resolved taken.
REQ-010 SHALL have port c_pc_write, output, 1 bit: PC write enable.
REQ-011 SHALL have port c_if_id_write, output, 1 bit: IF/ID write enable.
REQ-012 SHALL have port c_id_ex_bubble, output, 1 bit: zero ID/EX controls.
REQ-013 SHALL have port c_if_id_flush, output, 1 bit: clear IF/ID to nop.
REQ-014 SHALL have port stall_cnt, output, 16 bits: stall-cycle count (HAZARD_STATS_EN only).

Function
REQ-015 SHALL decode dest reg: opcode 0 -> instru[15:11]; lw/addi -> instru[20:16]; others -> none. Reg 0 never hazards.
REQ-016 SHALL treat id rt as a source only for R-type, beq, bne, sw; rs is always a source.
REQ-017 SHALL flag load-use (depth 1) when c_ex_MemRead and ex dest matches an id source.
REQ-018 SHALL flag branch-ALU (depth 1) when id is beq/bne, c_ex_RegWrite, !c_ex_MemRead, and ex dest matches rs/rt.
REQ-019 SHALL flag branch-load-MEM (depth 1) when id is beq/bne, c_ex_mem_MemRead, and ex_mem dest matches rs/rt.
REQ-020 SHALL flag branch-load-EX (depth 2) when id is beq/bne, c_ex_MemRead, and ex dest matches rs/rt; depth 2 takes priority.
REQ-021 SHALL use FSM states IDLE, HOLD.
REQ-022 IDLE with no hazard: c_pc_write=1, c_if_id_write=1, c_id_ex_bubble=0.
REQ-023 IDLE with hazard: same cycle c_pc_write=0, c_if_id_write=0, c_id_ex_bubble=1; depth 2 -> HOLD next edge, depth 1 -> stay IDLE.
REQ-024 HOLD: stall outputs asserted unconditionally for exactly one cycle, then -> IDLE, where hazards re-evaluate.
REQ-025 c_if_id_flush SHALL equal c_id_branch_taken AND not stalling; a taken branch during any stall cycle is ignored.
REQ-026 SHALL have zero-cycle latency: all outputs combinational from state and inputs; only state and stall_cnt are registered.

Reset
REQ-027 Reset SHALL force state IDLE, stall_cnt=0, c_pc_write=1, c_if_id_write=1, c_id_ex_bubble=0, c_if_id_flush=0.
REQ-028 Reset asserted in HOLD SHALL abort the hold immediately; no residual stall after release.

Configuration
REQ-029 With HAZARD_STATS_EN defined: stall_cnt increments on each stall cycle, saturates at 16'hFFFF, never wraps.
REQ-030 Without HAZARD_STATS_EN: stall_cnt SHALL be tied to 0 and no counter register SHALL exist.

Structure
REQ-031 Opcodes (R-type 0, lw, sw, addi, beq, bne), FSM state encoding, and depth constants SHALL live in the shared pipeline package.
REQ-032 Dest/source decode SHALL be one sub-module, hazard_reg_decode, instantiated per pipeline stage.

Verification
REQ-033 Load-use: ex=lw $t0,0($s0), id=add $t1,$t0,$t2 -> one cycle pc_write=0, bubble=1; then normal.
REQ-034 No false stall: ex=lw $t0, id=addi $t1,$t0,4 stalls; id=addi $t0,$t1,4 does not; dest $zero never stalls.
REQ-035 Branch after lw: ex=lw $t0, id=beq $t0,$t1 -> 2 stall cycles (IDLE->HOLD->IDLE), then branch resolves.
REQ-036 Branch after add: ex=add $t0, id=bne $t0,$t1 -> exactly 1 stall cycle.
REQ-037 Flush: c_id_branch_taken=1 with no hazard -> c_if_id_flush=1 for 1 cycle; the same input during a stall -> flush=0.
REQ-038 Reset in HOLD -> outputs return to reset values asynchronously; stall_cnt=0; with HAZARD_STATS_EN, a forced count of 16'hFFFF stays at FFFF on a further stall.

Source files
------------

// File: rtl/hazard_stall_pkg.sv
// Shared pipeline constants for the hazard/stall unit: opcodes, FSM encoding
// and hazard-depth codes.
package hazard_stall_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 16;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  typedef logic [1:0] depth_t;
  localparam depth_t DEPTH_NONE = 2'd0;
  localparam depth_t DEPTH_1    = 2'd1;
  localparam depth_t DEPTH_2    = 2'd2;

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/hazard_stall_if.sv
// Pipeline-side view of the hazard/stall unit: stage instructions, stage
// controls in, stall/flush controls out.
interface hazard_stall_if;
  import hazard_stall_pkg::*;

  logic [INSTR_W-1:0] id_instru;
  logic [INSTR_W-1:0] ex_instru;
  logic [INSTR_W-1:0] ex_mem_instru;
  logic               c_ex_MemRead;
  logic               c_ex_RegWrite;
  logic               c_ex_mem_MemRead;
  logic               c_id_branch_taken;
  logic               c_pc_write;
  logic               c_if_id_write;
  logic               c_id_ex_bubble;
  logic               c_if_id_flush;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output id_instru, ex_instru, ex_mem_instru,
    output c_ex_MemRead, c_ex_RegWrite, c_ex_mem_MemRead, c_id_branch_taken,
    input  c_pc_write, c_if_id_write, c_id_ex_bubble, c_if_id_flush, stall_cnt
  );

  modport slave (
    input  id_instru, ex_instru, ex_mem_instru,
    input  c_ex_MemRead, c_ex_RegWrite, c_ex_mem_MemRead, c_id_branch_taken,
    output c_pc_write, c_if_id_write, c_id_ex_bubble, c_if_id_flush, stall_cnt
  );
endinterface

// File: rtl/hazard_reg_decode.sv
// Register-usage decode of one pipeline stage's instruction: destination,
// source fields and whether rt is actually read.
module hazard_reg_decode
  import hazard_stall_pkg::*;
(
  input  logic [INSTR_W-1:0] instru,
  output logic [REG_W-1:0]   dest,
  output logic [REG_W-1:0]   rs,
  output logic [REG_W-1:0]   rt,
  output logic               rt_src,
  output logic               branch
);

  logic [5:0] op;
  logic       unused_low;

  assign op         = instru[31:26];
  assign rs         = instru[25:21];
  assign rt         = instru[20:16];
  assign unused_low = ^instru[10:0];

  // A zero dest means "writes nothing", so $zero can never create a hazard.
  always_comb begin
    dest = '0;
    case (op)
      OP_RTYPE:       dest = instru[15:11];
      OP_LW, OP_ADDI: dest = instru[20:16];
      default:        dest = '0;
    endcase
  end

  assign rt_src = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  assign branch = is_branch_op(op);

endmodule

// File: rtl/hazard_stall.sv
// Load-use / branch-operand hazard detection with a two-state stall FSM.
// Optional stall-cycle statistics counter enabled by HAZARD_STATS_EN.
module hazard_stall
  import hazard_stall_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  hazard_stall_if.slave hz
);

  logic [REG_W-1:0] id_rs, id_rt, ex_dest, mem_dest;
  logic             id_rt_src, id_branch;
  logic [REG_W-1:0] unused_id_dest, unused_ex_rs, unused_ex_rt, unused_mem_rs, unused_mem_rt;
  logic             unused_ex_rt_src, unused_ex_branch, unused_mem_rt_src, unused_mem_branch;

  hazard_reg_decode u_dec_id (
    .instru(hz.id_instru), .dest(unused_id_dest), .rs(id_rs), .rt(id_rt),
    .rt_src(id_rt_src), .branch(id_branch)
  );

  hazard_reg_decode u_dec_ex (
    .instru(hz.ex_instru), .dest(ex_dest), .rs(unused_ex_rs), .rt(unused_ex_rt),
    .rt_src(unused_ex_rt_src), .branch(unused_ex_branch)
  );

  hazard_reg_decode u_dec_mem (
    .instru(hz.ex_mem_instru), .dest(mem_dest), .rs(unused_mem_rs), .rt(unused_mem_rt),
    .rt_src(unused_mem_rt_src), .branch(unused_mem_branch)
  );

  logic   ex_hit_src, ex_hit_br, mem_hit_br;
  logic   load_use, br_alu, br_mem, br_ex;
  depth_t depth;
  logic   stall;
  logic [0:0] state, state_nxt;

  assign ex_hit_src = (ex_dest != '0) &&
                      ((ex_dest == id_rs) || (id_rt_src && (ex_dest == id_rt)));
  assign ex_hit_br  = (ex_dest != '0) && ((ex_dest == id_rs) || (ex_dest == id_rt));
  assign mem_hit_br = (mem_dest != '0) && ((mem_dest == id_rs) || (mem_dest == id_rt));

  assign load_use = hz.c_ex_MemRead && ex_hit_src;
  assign br_alu   = id_branch && hz.c_ex_RegWrite && !hz.c_ex_MemRead && ex_hit_br;
  assign br_mem   = id_branch && hz.c_ex_mem_MemRead && mem_hit_br;
  assign br_ex    = id_branch && hz.c_ex_MemRead && ex_hit_br;

  always_comb begin
    depth = DEPTH_NONE;
    if (br_ex)
      depth = DEPTH_2;
    else if (load_use || br_alu || br_mem)
      depth = DEPTH_1;
  end

  // Reset gates the outputs directly so they recover without waiting for an edge.
  assign stall     = !reset && ((state == ST_HOLD) || (depth != DEPTH_NONE));
  assign state_nxt = ((state == ST_IDLE) && (depth == DEPTH_2)) ? ST_HOLD : ST_IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  assign hz.c_pc_write     = !stall;
  assign hz.c_if_id_write  = !stall;
  assign hz.c_id_ex_bubble = stall;
  assign hz.c_if_id_flush  = !reset && hz.c_id_branch_taken && !stall;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign hz.stall_cnt = stall_cnt_q;
`else
  assign hz.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall.sv
// Self-checking bench for hazard_stall: directed hazard scenarios plus random
// instruction mixes against a rule-level reference model.
module tb_hazard_stall;

  logic clk = 1'b0;
  logic reset;

  hazard_stall_if bus ();

  hazard_stall dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int stall_seen = 0;
  bit m_hold = 1'b0;
  int unsigned m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input int rd, input int rs, input int rt);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  // Reference rules: which register an instruction writes and which it reads.
  function automatic int dest_of(input logic [31:0] i);
    int op = int'(i[31:26]);
    if (op == 0) return int'(i[15:11]);
    if (op == 35 || op == 8) return int'(i[20:16]);
    return 0;
  endfunction

  function automatic bit is_br(input logic [31:0] i);
    return (i[31:26] == 6'd4) || (i[31:26] == 6'd5);
  endfunction

  function automatic bit reads(input logic [31:0] i, input int r);
    int op = int'(i[31:26]);
    bit rt_used = (op == 0) || (op == 4) || (op == 5) || (op == 43);
    if (r == 0) return 1'b0;
    return (int'(i[25:21]) == r) || (rt_used && int'(i[20:16]) == r);
  endfunction

  function automatic int hazard_depth();
    logic [31:0] id = bus.id_instru;
    int ed = dest_of(bus.ex_instru);
    int md = dest_of(bus.ex_mem_instru);
    if (is_br(id) && bus.c_ex_MemRead && reads(id, ed)) return 2;
    if (bus.c_ex_MemRead && reads(id, ed)) return 1;
    if (is_br(id) && bus.c_ex_RegWrite && !bus.c_ex_MemRead && reads(id, ed)) return 1;
    if (is_br(id) && bus.c_ex_mem_MemRead && reads(id, md)) return 1;
    return 0;
  endfunction

  task automatic drive(input logic [31:0] id, input logic [31:0] ex, input logic [31:0] mem,
                       input bit ex_rd, input bit ex_wr, input bit mem_rd, input bit taken);
    bus.id_instru         = id;
    bus.ex_instru         = ex;
    bus.ex_mem_instru     = mem;
    bus.c_ex_MemRead      = ex_rd;
    bus.c_ex_RegWrite     = ex_wr;
    bus.c_ex_mem_MemRead  = mem_rd;
    bus.c_id_branch_taken = taken;
  endtask

  // Check one cycle's combinational outputs mid-cycle, then advance the model at the edge.
  task automatic step(input string tag);
    int d;
    bit e_stall;
    #2;
    d = hazard_depth();
    e_stall = reset ? 1'b0 : (m_hold || (d != 0));
    if (bus.c_id_ex_bubble === 1'b1) stall_seen++;
    check({tag, ".pc_write"}, 32'(bus.c_pc_write), 32'(!e_stall));
    check({tag, ".if_id_write"}, 32'(bus.c_if_id_write), 32'(!e_stall));
    check({tag, ".bubble"}, 32'(bus.c_id_ex_bubble), 32'(e_stall));
    check({tag, ".flush"}, 32'(bus.c_if_id_flush),
          32'(!reset && bus.c_id_branch_taken && !e_stall));
    check({tag, ".stall_cnt"}, 32'(bus.stall_cnt), m_cnt);
    @(posedge clk);
    if (!reset) begin
      if (STATS && e_stall && m_cnt < 32'hFFFF) m_cnt++;
      m_hold = !m_hold && (d == 2);
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [7];
    int k;
    ops = '{6'd0, 6'd35, 6'd43, 6'd8, 6'd4, 6'd5, 6'd13};
    k = $urandom_range(0, 6);
    if (ops[k] == 6'd0)
      return r_type($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    return i_type(int'(ops[k]), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
  endfunction

  localparam int T0 = 8, T1 = 9, T2 = 10, S0 = 16;
  logic [31:0] nop, lw_t0, lw_zero, add_t1, add_t0, addi_a, addi_b, beq_t0, bne_t0, add_z;

  initial begin
    nop     = 32'd0;
    lw_t0   = i_type(35, S0, T0, 0);
    lw_zero = i_type(35, S0, 0, 0);
    add_t1  = r_type(T1, T0, T2);
    add_t0  = r_type(T0, T1, T2);
    addi_a  = i_type(8, T0, T1, 4);
    addi_b  = i_type(8, T1, T0, 4);
    beq_t0  = i_type(4, T0, T1, 3);
    bne_t0  = i_type(5, T0, T1, 3);
    add_z   = r_type(T1, 0, 0);

    reset = 1'b1;
    drive(add_t1, lw_t0, nop, 1, 1, 0, 1);
    step("reset_a");
    step("reset_b");
    reset = 1'b0;

    stall_seen = 0;
    drive(add_t1, lw_t0, nop, 1, 1, 0, 0);
    step("lu_1");
    drive(add_t1, nop, lw_t0, 0, 0, 1, 0);
    step("lu_2");
    check("lu_stalls", stall_seen, 1);

    stall_seen = 0;
    drive(addi_a, lw_t0, nop, 1, 1, 0, 0);
    step("addi_src");
    check("addi_src_stalls", stall_seen, 1);
    stall_seen = 0;
    drive(addi_b, lw_t0, nop, 1, 1, 0, 0);
    step("addi_rt_dst");
    drive(add_z, lw_zero, nop, 1, 1, 0, 0);
    step("zero_dest");
    check("no_false_stalls", stall_seen, 0);

    stall_seen = 0;
    drive(beq_t0, lw_t0, nop, 1, 1, 0, 0);
    step("blw_1");
    drive(beq_t0, nop, lw_t0, 0, 0, 1, 0);
    step("blw_2");
    drive(beq_t0, nop, nop, 0, 0, 0, 1);
    step("blw_3");
    check("blw_stalls", stall_seen, 2);

    stall_seen = 0;
    drive(bne_t0, add_t0, nop, 0, 1, 0, 0);
    step("badd_1");
    drive(bne_t0, nop, add_t0, 0, 0, 0, 1);
    step("badd_2");
    check("badd_stalls", stall_seen, 1);

    drive(add_t1, add_t0, nop, 0, 1, 0, 1);
    step("flush_free");
    drive(add_t1, lw_t0, nop, 1, 1, 0, 1);
    step("flush_stall");

    drive(beq_t0, lw_t0, nop, 1, 1, 0, 1);
    step("hold_enter");
    #2;
    reset = 1'b1;
    #1;
    check("rst_hold.pc_write", 32'(bus.c_pc_write), 1);
    check("rst_hold.bubble", 32'(bus.c_id_ex_bubble), 0);
    check("rst_hold.flush", 32'(bus.c_if_id_flush), 0);
    check("rst_hold.stall_cnt", 32'(bus.stall_cnt), 0);
    m_hold = 1'b0;
    m_cnt  = 0;
    step("rst_hold");
    reset = 1'b0;
    stall_seen = 0;
    drive(nop, nop, nop, 0, 0, 0, 0);
    step("post_rst");
    check("post_rst_stalls", stall_seen, 0);

`ifdef HAZARD_STATS_EN
    force dut.stall_cnt_q = 16'hFFFF;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 32'hFFFF;
    drive(add_t1, lw_t0, nop, 1, 1, 0, 0);
    step("sat_1");
    drive(nop, nop, nop, 0, 0, 0, 0);
    step("sat_2");
`endif

    for (int n = 0; n < 400; n++) begin
      drive(rand_instr(), rand_instr(), rand_instr(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
